// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: runs the power-up init sequence, then turns
// CPU strobe edges into timed EN pulses through a one-deep request slot.
module lcd_ctrl #(
   parameter int unsigned T_PWRUP = 750000,
   parameter int unsigned T_AS    = 2,
   parameter int unsigned T_EN    = 12,
   parameter int unsigned T_H     = 2,
   parameter int unsigned T_EXEC  = 2000,
   parameter int unsigned T_CLR   = 82000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lcd_word_i,
   output logic        lcd_on_o,
   output logic        lcd_blon_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_busy_o,
   output logic        init_done_o,
   output logic        overrun_o
);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT_LOAD,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT,
      S_IDLE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] phase_len;
   logic        phase_done;
   logic [1:0]  idx_q, idx_d;
   logic        init_done_q, init_done_d;
   logic        pend_valid_q, pend_valid_d;
   logic        pend_rs_q, pend_rs_d;
   logic [7:0]  pend_data_q, pend_data_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        en_q, en_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        prev_stb_q;
   logic        on_q, blon_q;
   logic        stb_edge, dequeue, is_clr_cmd;
   logic        unused_word_bits;

   assign unused_word_bits = ^{lcd_word_i[29:11], lcd_word_i[8]};

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   assign stb_edge   = lcd_word_i[10] & ~prev_stb_q;
   assign dequeue    = (state_q == S_IDLE) & pend_valid_q;
   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   assign is_clr_cmd = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);

   always_comb begin
      // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
      phase_len = 32'd1;
      case (state_q)
         S_PWRUP: phase_len = T_PWRUP;
         S_SETUP: phase_len = T_AS;
         S_PULSE: phase_len = T_EN;
         S_HOLD:  phase_len = T_H;
         S_WAIT:  phase_len = is_clr_cmd ? T_CLR : T_EXEC;
         default: phase_len = 32'd1;
      endcase
   end

   assign phase_done = (cnt_q == phase_len - 32'd1);

   // State register
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
      if (rst_i) state_q <= S_PWRUP;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_PWRUP:     if (phase_done) state_d = S_INIT_LOAD;
         S_INIT_LOAD: state_d = S_SETUP;
         S_SETUP:     if (phase_done) state_d = S_PULSE;
         S_PULSE:     if (phase_done) state_d = S_HOLD;
         S_HOLD:      if (phase_done) state_d = S_WAIT;
         S_WAIT: begin
            if (phase_done) begin
               if (!init_done_q && idx_q != 2'd3) state_d = S_INIT_LOAD;
               else                               state_d = S_IDLE;
            end
         end
         S_IDLE:      if (pend_valid_q) state_d = S_SETUP;
         default:     state_d = S_PWRUP;
      endcase
   end

   // Datapath: request slot, transfer registers, init index, phase counter
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_rs_d    = pend_rs_q;
      pend_data_d  = pend_data_q;
      overrun_d    = overrun_q;
      rs_d         = rs_q;
      data_d       = data_q;
      idx_d        = idx_q;
      init_done_d  = init_done_q;

      if (dequeue) pend_valid_d = 1'b0;
      // A slot freed this cycle accepts the new request without an overrun.
      if (stb_edge) begin
         if (pend_valid_q && !dequeue) begin
            overrun_d = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_rs_d    = lcd_word_i[9];
            pend_data_d  = lcd_word_i[7:0];
         end
      end

      // Bus values are loaded on the edge that enters SETUP and held until the next transfer.
      if (state_q == S_INIT_LOAD) begin
         rs_d   = 1'b0;
         data_d = init_cmd(idx_q);
      end else if (dequeue) begin
         rs_d   = pend_rs_q;
         data_d = pend_data_q;
      end

      if (state_q == S_PWRUP) idx_d = 2'd0;
      if (state_q == S_WAIT && phase_done && !init_done_q) begin
         if (idx_q == 2'd3) init_done_d = 1'b1;
         else               idx_d       = idx_q + 2'd1;
      end

      if (state_d != state_q || state_q == S_IDLE) cnt_d = 32'd0;
      else                                         cnt_d = cnt_q + 32'd1;
   end

   // Output logic
   always_comb begin
      en_d   = (state_d == S_PULSE);
      busy_d = (state_d != S_IDLE) | pend_valid_d;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: the pending slot payload is reset too; it is two small registers, not a memory array.
      if (rst_i) begin
         cnt_q        <= 32'd0;
         idx_q        <= 2'd0;
         init_done_q  <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_rs_q    <= 1'b0;
         pend_data_q  <= 8'h00;
         rs_q         <= 1'b0;
         data_q       <= 8'h00;
         en_q         <= 1'b0;
         busy_q       <= 1'b1;
         overrun_q    <= 1'b0;
         prev_stb_q   <= 1'b1;
         on_q         <= 1'b0;
         blon_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         init_done_q  <= init_done_d;
         pend_valid_q <= pend_valid_d;
         pend_rs_q    <= pend_rs_d;
         pend_data_q  <= pend_data_d;
         rs_q         <= rs_d;
         data_q       <= data_d;
         en_q         <= en_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         prev_stb_q   <= lcd_word_i[10];
         on_q         <= lcd_word_i[31];
         blon_q       <= lcd_word_i[30];
      end
   end

   assign lcd_on_o    = on_q;
   assign lcd_blon_o  = blon_q;
   assign lcd_rs_o    = rs_q;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = en_q;
   assign lcd_data_o  = data_q;
   assign lcd_busy_o  = busy_q;
   assign init_done_o = init_done_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: a scoreboard of expected {RS,DATA} writes is
// popped by a pin monitor at every EN rise; scenario tasks check timing and status.
module tb_lcd_ctrl;

   localparam int T_PWRUP = 20;
   localparam int T_AS    = 2;
   localparam int T_EN    = 3;
   localparam int T_H     = 2;
   localparam int T_EXEC  = 10;
   localparam int T_CLR   = 30;

   // Derived LCD timing: rise of first init pulse after reset release, and
   // rise-to-rise spacing for a given post-write wait (one INIT_LOAD/IDLE cycle between).
   localparam int FIRST_RISE = T_PWRUP + 1 + T_AS;
   localparam int GAP_EXEC   = T_EN + T_H + T_EXEC + 1 + T_AS;
   localparam int GAP_CLR    = T_EN + T_H + T_CLR + 1 + T_AS;
   localparam int RISE_TO_IDLE_EXEC = T_EN + T_H + T_EXEC;
   // From the strobe cycle: capture, one IDLE cycle, then SETUP+PULSE+HOLD+WAIT.
   localparam int STB_TO_IDLE_EXEC = 2 + T_AS + T_EN + T_H + T_EXEC;
   localparam int STB_TO_IDLE_CLR  = 2 + T_AS + T_EN + T_H + T_CLR;
   localparam logic [31:0] BASE = 32'hC000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word = BASE;
   logic        lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en;
   logic [7:0]  lcd_data;
   logic        lcd_busy, init_done, overrun;

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          init_c0 = 0;
   logic [8:0]  sb[$];
   int          rise_q[$];

   lcd_ctrl #(
      .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_EN(T_EN),
      .T_H(T_H), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .lcd_word_i  (word),
      .lcd_on_o    (lcd_on),
      .lcd_blon_o  (lcd_blon),
      .lcd_rs_o    (lcd_rs),
      .lcd_rw_o    (lcd_rw),
      .lcd_en_o    (lcd_en),
      .lcd_data_o  (lcd_data),
      .lcd_busy_o  (lcd_busy),
      .init_done_o (init_done),
      .overrun_o   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // Pin monitor: pops the scoreboard on each EN rise and checks setup, pulse width and hold.
   task automatic monitor();
      logic       prev_en = 1'b0;
      int         hi = 0;
      int         hold = 0;
      logic [8:0] cur, held = '0, h1 = '0, h2 = '0, exp_v;
      forever begin
         @(negedge clk);
         cur = {lcd_rs, lcd_data};
         if (rst) begin
            prev_en = 1'b0;
            hi      = 0;
            hold    = 0;
         end else begin
            if (hold > 0) begin
               checks++;
               if (cur !== held) begin
                  failures++;
                  $display("FAIL hold_stable cyc=%0d got=%h exp=%h", cyc, cur, held);
               end
               hold--;
            end
            if (lcd_en && !prev_en) begin
               rise_q.push_back(cyc);
               checks++;
               if (h1 !== cur || h2 !== cur) begin
                  failures++;
                  $display("FAIL setup_stable cyc=%0d got=%h,%h exp=%h", cyc, h2, h1, cur);
               end
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_write cyc=%0d got=%h exp=none", cyc, cur);
               end else begin
                  exp_v = sb.pop_front();
                  if (cur !== exp_v) begin
                     failures++;
                     $display("FAIL write_value cyc=%0d got=%h exp=%h", cyc, cur, exp_v);
                  end
               end
               held = cur;
               hi   = 1;
            end else if (lcd_en) begin
               hi++;
               checks++;
               if (cur !== held) begin
                  failures++;
                  $display("FAIL pulse_stable cyc=%0d got=%h exp=%h", cyc, cur, held);
               end
            end else if (prev_en) begin
               checks++;
               if (hi !== T_EN) begin
                  failures++;
                  $display("FAIL en_width cyc=%0d got=%0d exp=%0d", cyc, hi, T_EN);
               end
               checks++;
               if (cur !== held) begin
                  failures++;
                  $display("FAIL hold_stable cyc=%0d got=%h exp=%h", cyc, cur, held);
               end
               hold = T_H - 1;
            end
            prev_en = lcd_en;
         end
         h2 = h1;
         h1 = cur;
      end
   endtask

   task automatic push_init();
      sb.push_back({1'b0, 8'h38});
      sb.push_back({1'b0, 8'h0C});
      sb.push_back({1'b0, 8'h01});
      sb.push_back({1'b0, 8'h06});
   endtask

   task automatic send(input logic rs, input logic [7:0] d, input bit expect_xfer, output int c);
      @(posedge clk); #1;
      word = BASE | 32'h0000_0400 | {22'd0, rs, 1'b0, d};
      c = cyc;
      if (expect_xfer) sb.push_back({rs, d});
      @(posedge clk); #1;
      word = BASE;
   endtask

   task automatic apply_reset(output int c0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      c0 = cyc;
      sb.delete();
      rise_q.delete();
      push_init();
   endtask

   task automatic wait_busy_low(input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (lcd_busy === 1'b0) begin
            c = cyc;
            break;
         end
      end
   endtask

   task automatic wait_init_done(input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (init_done === 1'b1) begin
            c = cyc;
            break;
         end
      end
   endtask

   task automatic wait_en_high(input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (lcd_en === 1'b1) begin
            c = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({lcd_en, lcd_rs, lcd_data, lcd_rw} !== 11'd0) begin
         failures++;
         $display("FAIL reset_bus got=%b exp=0", {lcd_en, lcd_rs, lcd_data, lcd_rw});
      end
      checks++;
      if ({lcd_on, lcd_blon} !== 2'b00) begin
         failures++;
         $display("FAIL reset_power got=%b exp=00", {lcd_on, lcd_blon});
      end
      checks++;
      if ({lcd_busy, init_done, overrun} !== 3'b100) begin
         failures++;
         $display("FAIL reset_status got=%b exp=100", {lcd_busy, init_done, overrun});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      init_c0 = cyc;
      push_init();
      @(negedge clk);
      checks++;
      if ({lcd_on, lcd_blon} !== 2'b00) begin
         failures++;
         $display("FAIL power_latency_early got=%b exp=00", {lcd_on, lcd_blon});
      end
      @(negedge clk);
      checks++;
      if ({lcd_on, lcd_blon} !== 2'b11) begin
         failures++;
         $display("FAIL power_follow got=%b exp=11", {lcd_on, lcd_blon});
      end
   endtask

   task automatic test_init();
      int c;
      wait_init_done(400, c);
      checks++;
      if (c - init_c0 !== FIRST_RISE + 2 * GAP_EXEC + GAP_CLR + RISE_TO_IDLE_EXEC) begin
         failures++;
         $display("FAIL init_done_time got=%0d exp=%0d", c - init_c0,
                  FIRST_RISE + 2 * GAP_EXEC + GAP_CLR + RISE_TO_IDLE_EXEC);
      end
      checks++;
      if (lcd_busy !== 1'b0) begin
         failures++;
         $display("FAIL init_busy_low got=%b exp=0", lcd_busy);
      end
      checks++;
      if (rise_q.size() !== 4) begin
         failures++;
         $display("FAIL init_pulse_count got=%0d exp=4", rise_q.size());
      end else begin
         checks++;
         if (rise_q[0] - init_c0 !== FIRST_RISE || rise_q[1] - rise_q[0] !== GAP_EXEC ||
             rise_q[2] - rise_q[1] !== GAP_EXEC || rise_q[3] - rise_q[2] !== GAP_CLR) begin
            failures++;
            $display("FAIL init_spacing got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                     rise_q[0] - init_c0, rise_q[1] - rise_q[0], rise_q[2] - rise_q[1],
                     rise_q[3] - rise_q[2], FIRST_RISE, GAP_EXEC, GAP_EXEC, GAP_CLR);
         end
      end
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL init_scoreboard got=%0d exp=0", sb.size());
      end
   endtask

   task automatic test_data_write();
      int cs, c;
      rise_q.delete();
      send(1'b1, 8'h41, 1'b1, cs);
      @(negedge clk);
      checks++;
      if (lcd_busy !== 1'b1) begin
         failures++;
         $display("FAIL data_busy_rise got=%b exp=1", lcd_busy);
      end
      wait_busy_low(100, c);
      checks++;
      if (c - cs !== STB_TO_IDLE_EXEC) begin
         failures++;
         $display("FAIL data_busy_len got=%0d exp=%0d", c - cs, STB_TO_IDLE_EXEC);
      end
      checks++;
      if (rise_q.size() !== 1 || rise_q[0] - cs !== 2 + T_AS) begin
         failures++;
         $display("FAIL data_rise_time got=%0d exp=%0d", rise_q.size() > 0 ? rise_q[0] - cs : -1, 2 + T_AS);
      end
   endtask

   task automatic test_clear_vs_cmd();
      int cs, c;
      send(1'b0, 8'h01, 1'b1, cs);
      wait_busy_low(200, c);
      checks++;
      if (c - cs !== STB_TO_IDLE_CLR) begin
         failures++;
         $display("FAIL clear_wait got=%0d exp=%0d", c - cs, STB_TO_IDLE_CLR);
      end
      send(1'b0, 8'h80, 1'b1, cs);
      wait_busy_low(200, c);
      checks++;
      if (c - cs !== STB_TO_IDLE_EXEC) begin
         failures++;
         $display("FAIL cmd_wait got=%0d exp=%0d", c - cs, STB_TO_IDLE_EXEC);
      end
   endtask

   task automatic test_back_to_back();
      int ca, cb, cc, c;
      rise_q.delete();
      send(1'b1, 8'h61, 1'b1, ca);
      send(1'b1, 8'h62, 1'b1, cb);
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_early got=%b exp=0", overrun);
      end
      send(1'b1, 8'h63, 1'b0, cc);
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set got=%b exp=1", overrun);
      end
      wait_busy_low(300, c);
      checks++;
      if (c - ca !== STB_TO_IDLE_EXEC + GAP_EXEC) begin
         failures++;
         $display("FAIL b2b_busy_len got=%0d exp=%0d", c - ca, STB_TO_IDLE_EXEC + GAP_EXEC);
      end
      checks++;
      if (rise_q.size() !== 2 || rise_q[1] - rise_q[0] !== GAP_EXEC) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d exp=2", rise_q.size());
      end
      checks++;
      if (overrun !== 1'b1 || sb.size() !== 0) begin
         failures++;
         $display("FAIL overrun_sticky got=%b,%0d exp=1,0", overrun, sb.size());
      end
   endtask

   task automatic test_reset_mid_pulse();
      int cs, p, c0, c;
      send(1'b1, 8'h33, 1'b1, cs);
      wait_en_high(50, p);
      checks++;
      if (p - cs !== 2 + T_AS) begin
         failures++;
         $display("FAIL mid_pulse_reach got=%0d exp=%0d", p - cs, 2 + T_AS);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      c0 = cyc;
      sb.delete();
      rise_q.delete();
      push_init();
      @(negedge clk);
      checks++;
      if ({lcd_en, init_done, overrun, lcd_busy} !== 4'b0001) begin
         failures++;
         $display("FAIL mid_reset_status got=%b exp=0001", {lcd_en, init_done, overrun, lcd_busy});
      end
      wait_init_done(400, c);
      checks++;
      if (rise_q.size() !== 4 || rise_q[0] - c0 !== FIRST_RISE) begin
         failures++;
         $display("FAIL restart_first_rise got=%0d exp=%0d", rise_q.size() > 0 ? rise_q[0] - c0 : -1, FIRST_RISE);
      end
      checks++;
      if (overrun !== 1'b0 || lcd_busy !== 1'b0) begin
         failures++;
         $display("FAIL restart_done got=%b%b exp=00", overrun, lcd_busy);
      end
   endtask

   task automatic test_stb_during_pwrup();
      int c0, cs, c, c2;
      apply_reset(c0);
      repeat (4) @(posedge clk);
      send(1'b1, 8'h55, 1'b1, cs);
      wait_init_done(400, c);
      checks++;
      if (lcd_busy !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL pwrup_queued got=%b%b exp=10", lcd_busy, overrun);
      end
      wait_busy_low(100, c2);
      checks++;
      if (rise_q.size() !== 5 || rise_q[4] - rise_q[3] !== GAP_EXEC) begin
         failures++;
         $display("FAIL pwrup_xfer got=%0d exp=5", rise_q.size());
      end
      checks++;
      if (rise_q.size() !== 5 || c2 - rise_q[4] !== RISE_TO_IDLE_EXEC) begin
         failures++;
         $display("FAIL pwrup_busy_end got=%0d exp=%0d", rise_q.size() == 5 ? c2 - rise_q[4] : -1, RISE_TO_IDLE_EXEC);
      end
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL final_scoreboard got=%0d exp=0", sb.size());
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_init();
      test_data_write();
      test_clear_vs_cmd();
      test_back_to_back();
      test_reset_mid_pulse();
      test_stb_during_pwrup();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
